// File: rtl/audio_meter_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// audio_meter_ctrl
//
// Sequencing controller for the LED audio meter. Accepts a handshaked stream
// of signed 8-bit samples and accumulates the absolute magnitude of
// 2^WINDOW_LOG2 samples per window. At the end of each window it computes the
// true mean and turns it into a level, 0..8. It then drives an MSB-first
// thermometer code. The display uses peak-hold with a timed decay of one LED
// per HOLD_WINDOWS completed windows.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset (priority over everything)
//   enable        run control; low returns the controller to IDLE
//   sample_valid  sample_data is valid this cycle
//   sample_data   two's-complement audio sample
//   sample_ready  controller accepts a sample this cycle (ACCUM only)
//   intensity     LED thermometer, MSB-first (1 LED = 8'b1000_0000)
//   level         currently displayed level, 0..8
//   window_done   one-cycle pulse in the cycle a window result is committed
//   overrun       sticky; a sample was offered while busy averaging/updating
// ---------------------------------------------------------------------------
module audio_meter_ctrl #(
  parameter int WINDOW_LOG2  = 8,
  parameter int HOLD_WINDOWS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       sample_valid,
  input  logic [7:0] sample_data,
  output logic       sample_ready,
  output logic [7:0] intensity,
  output logic [3:0] level,
  output logic       window_done,
  output logic       overrun
);

  // The sum holds 2^WINDOW_LOG2 magnitudes of at most 128 each. It therefore
  // needs WINDOW_LOG2+8 bits and cannot overflow.
  localparam int         SUM_W     = WINDOW_LOG2 + 8;
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_WINDOWS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_AVERAGE = 2'd2,
    ST_UPDATE  = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_nx_s;
  logic [SUM_W-1:0]     sum_r;
  logic [WINDOW_LOG2-1:0] count_r;
  logic [7:0]           hold_cnt_r;
  logic [3:0]           new_level_r;
  logic                 sample_ready_r;
  logic [7:0]           intensity_r;
  logic [3:0]           level_r;
  logic                 window_done_r;
  logic                 overrun_r;

  logic                 accept_s;
  logic                 last_sample_s;
  logic                 busy_s;
  logic [7:0]           avg_s;
  logic [3:0]           level_nx_s;
  logic [7:0]           hold_nx_s;

  // Absolute value as an 8-bit unsigned number. -128 maps to 128, which fits
  // because the result is unsigned.
  function automatic logic [7:0] abs_mag(input logic [7:0] s);
    logic [7:0] m;
    if (s[7]) begin
      m = 8'(~s + 8'd1);
    end else begin
      m = s;
    end
    return m;
  endfunction

  // Position of the most significant set bit, plus one. Zero maps to zero.
  function automatic logic [3:0] msb_level(input logic [7:0] v);
    logic [3:0] lvl;
    lvl = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        lvl = 4'(i + 1);
      end else begin
        lvl = lvl;
      end
    end
    return lvl;
  endfunction

  // Top `lv` bits set; any level of 8 or more lights every LED.
  function automatic logic [7:0] thermo(input logic [3:0] lv);
    logic [7:0] t;
    t = 8'h00;
    for (int i = 0; i < 8; i++) begin
      t[7-i] = (4'(i) < lv);
    end
    return t;
  endfunction

  // A sample is taken only in ACCUM while the meter is enabled. A valid
  // sample in the same cycle that enable drops belongs to the aborted window.
  assign accept_s      = (state_r == ST_ACCUM) && enable && sample_valid;
  assign last_sample_s = accept_s && (&count_r);
  assign busy_s        = (state_r == ST_AVERAGE) || (state_r == ST_UPDATE);

  // The mean is a plain right shift, because the window size is a power of two.
  assign avg_s = sum_r[SUM_W-1:WINDOW_LOG2];

  // Next-state logic for the window sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          state_nx_s = ST_ACCUM;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (!enable) begin
          state_nx_s = ST_IDLE;
        end else if (last_sample_s) begin
          state_nx_s = ST_AVERAGE;
        end else begin
          state_nx_s = ST_ACCUM;
        end
      end
      // Once the window is full it always completes and commits, even if
      // enable drops during averaging.
      ST_AVERAGE: begin
        state_nx_s = ST_UPDATE;
      end
      ST_UPDATE: begin
        if (enable) begin
          state_nx_s = ST_ACCUM;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Peak-hold display rule: rise immediately, decay one LED per hold period.
  always_comb begin
    level_nx_s = level_r;
    hold_nx_s  = hold_cnt_r;
    if (new_level_r >= level_r) begin
      level_nx_s = new_level_r;
      hold_nx_s  = 8'd0;
    end else if (hold_cnt_r == HOLD_LAST) begin
      level_nx_s = level_r - 4'd1;
      hold_nx_s  = 8'd0;
    end else begin
      level_nx_s = level_r;
      hold_nx_s  = hold_cnt_r + 8'd1;
    end
  end

  // State register, with outputs registered from the next state. This makes
  // each output valid in the same cycle as the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      sample_ready_r <= 1'b0;
      window_done_r  <= 1'b0;
      overrun_r      <= 1'b0;
    end else begin
      state_r        <= state_nx_s;
      sample_ready_r <= (state_nx_s == ST_ACCUM);
      window_done_r  <= (state_nx_s == ST_UPDATE);
      if (busy_s && enable && sample_valid) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  // Window datapath: accumulate, average, commit the display.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_r       <= '0;
      count_r     <= '0;
      hold_cnt_r  <= 8'd0;
      new_level_r <= 4'd0;
      level_r     <= 4'd0;
      intensity_r <= 8'h00;
    end else begin
      case (state_r)
        ST_ACCUM: begin
          if (!enable) begin
            // Abort: drop the partial window and leave the display untouched.
            sum_r   <= '0;
            count_r <= '0;
          end else if (accept_s) begin
            sum_r   <= sum_r + SUM_W'(abs_mag(sample_data));
            count_r <= count_r + 1'b1;
          end else begin
            sum_r   <= sum_r;
            count_r <= count_r;
          end
        end
        ST_AVERAGE: begin
          new_level_r <= msb_level(avg_s);
        end
        ST_UPDATE: begin
          level_r     <= level_nx_s;
          intensity_r <= thermo(level_nx_s);
          hold_cnt_r  <= hold_nx_s;
          sum_r       <= '0;
          count_r     <= '0;
        end
        ST_IDLE: begin
          sum_r   <= '0;
          count_r <= '0;
        end
        default: begin
          sum_r   <= '0;
          count_r <= '0;
        end
      endcase
    end
  end

  assign sample_ready = sample_ready_r;
  assign intensity    = intensity_r;
  assign level        = level_r;
  assign window_done  = window_done_r;
  assign overrun      = overrun_r;

endmodule

// File: tb/tb_audio_meter_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for audio_meter_ctrl. A small-window instance (4 samples,
// hold of 2 windows) gets directed and randomized traffic. Each completed
// window is predicted from the accepted magnitudes with plain arithmetic and
// queued. A monitor pops the queue on every window_done. A default-parameter
// instance covers the 256-sample window.
module tb_audio_meter_ctrl;

  localparam int WA = 2;
  localparam int HA = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       a_enable, a_valid;
  logic [7:0] a_data;
  logic       a_ready, a_done, a_overrun;
  logic [7:0] a_intensity;
  logic [3:0] a_level;
  logic       b_enable, b_valid;
  logic [7:0] b_data;
  logic       b_ready, b_done, b_overrun;
  logic [7:0] b_intensity;
  logic [3:0] b_level;

  audio_meter_ctrl #(.WINDOW_LOG2(WA), .HOLD_WINDOWS(HA)) dut_a (
    .clk(clk), .reset(reset), .enable(a_enable), .sample_valid(a_valid),
    .sample_data(a_data), .sample_ready(a_ready), .intensity(a_intensity),
    .level(a_level), .window_done(a_done), .overrun(a_overrun)
  );

  audio_meter_ctrl dut_b (
    .clk(clk), .reset(reset), .enable(b_enable), .sample_valid(b_valid),
    .sample_data(b_data), .sample_ready(b_ready), .intensity(b_intensity),
    .level(b_level), .window_done(b_done), .overrun(b_overrun)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int cyc;
    int lvl;
    int inten;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend;
  bit   chk_pending = 1'b0;
  bit   mon_on      = 1'b0;

  // Reference model state
  int part_q[$];
  int m_level, m_hold, last_cyc, ov_from;
  bit en_prev;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int level_of(input int avg);
    int n = 0;
    while ((1 << n) <= avg) n++;
    return n;
  endfunction

  function automatic int thermo_of(input int lv);
    return (255 << (8 - lv)) & 255;
  endfunction

  task automatic model_reset();
    part_q.delete();
    exp_q.delete();
    chk_pending = 1'b0;
    m_level  = 0;
    m_hold   = 0;
    last_cyc = -100;
    ov_from  = 1 << 30;
    en_prev  = 1'b0;
  endtask

  // Window complete: the mean of the magnitudes and the peak-hold rule.
  task automatic complete_window(input int c);
    int sum, avg, nl;
    exp_t e;
    sum = 0;
    foreach (part_q[i]) sum += part_q[i];
    avg = sum / (1 << WA);
    nl  = level_of(avg);
    if (nl >= m_level) begin
      m_level = nl;
      m_hold  = 0;
    end else if (m_hold == HA - 1) begin
      m_level = m_level - 1;
      m_hold  = 0;
    end else begin
      m_hold = m_hold + 1;
    end
    e.cyc   = c + 2;
    e.lvl   = m_level;
    e.inten = thermo_of(m_level);
    exp_q.push_back(e);
    part_q.delete();
    last_cyc = c;
  endtask

  // One cycle of stimulus for instance A, with the model updated to match.
  task automatic drive_a(input bit en, input bit vld, input logic [7:0] d, output bit acc);
    bit rdy, busy;
    int c, s;
    @(negedge clk);
    c    = cyc;
    rdy  = a_ready;
    busy = (c == last_cyc + 1) || (c == last_cyc + 2);
    if (busy) check("ready_low_busy", int'(rdy), 0);
    else if (c == last_cyc + 3 && en_prev) check("ready_after_update", int'(rdy), 1);
    a_enable = en;
    a_valid  = vld && en;
    a_data   = d;
    if (a_valid && busy && (c + 1 < ov_from)) ov_from = c + 1;
    acc = a_valid && rdy;
    if (acc) begin
      s = $signed(d);
      part_q.push_back(s < 0 ? -s : s);
      if (part_q.size() == (1 << WA)) complete_window(c);
    end else if (!en && !busy) begin
      part_q.delete();
    end
    en_prev = en;
  endtask

  task automatic send_a(input logic [7:0] d);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      drive_a(1'b1, 1'b1, d, acc);
      tries++;
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic idle_a(input int n);
    bit acc;
    repeat (n) drive_a(1'b1, 1'b0, 8'h00, acc);
  endtask

  // Reset with enable and sample_valid held high; the sample must be ignored.
  task automatic do_reset();
    mon_on = 1'b0;
    @(negedge clk);
    reset = 1'b1; a_enable = 1'b1; a_valid = 1'b1; a_data = 8'h55;
    b_enable = 1'b0; b_valid = 1'b0; b_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_intensity", int'(a_intensity), 0);
    check("rst_level", int'(a_level), 0);
    check("rst_ready", int'(a_ready), 0);
    check("rst_overrun", int'(a_overrun), 0);
    check("rst_done", int'(a_done), 0);
    reset = 1'b0; a_valid = 1'b0; a_enable = 1'b1;
    model_reset();
    @(negedge clk);
    check("accum_after_reset", int'(a_ready), 1);
    en_prev = 1'b1;
    mon_on  = 1'b1;
  endtask

  // Monitor: window_done timing, committed display and sticky overrun.
  always @(negedge clk) begin
    if (mon_on) begin
      if (chk_pending) begin
        check("level", int'(a_level), pend.lvl);
        check("intensity", int'(a_intensity), pend.inten);
        chk_pending = 1'b0;
      end
      if (a_done) begin
        if (exp_q.size() == 0) begin
          check("spurious_window_done", 1, 0);
        end else begin
          pend = exp_q.pop_front();
          check("window_done_cycle", cyc, pend.cyc);
          chk_pending = 1'b1;
        end
      end
      check("overrun", int'(a_overrun), (cyc >= ov_from) ? 1 : 0);
    end
  end

  initial begin
    bit acc, found;
    logic [7:0] mask, d;
    int got, guard;
    reset = 1'b1; a_enable = 1'b0; a_valid = 1'b0; a_data = 8'h00;
    b_enable = 1'b0; b_valid = 1'b0; b_data = 8'h00;
    model_reset();

    do_reset();

    // Back-to-back +16/-16: mean 16, level 5.
    send_a(8'h10); send_a(8'hF0); send_a(8'h10); send_a(8'hF0);
    idle_a(4);
    check("dir_level5", int'(a_level), 5);
    check("dir_int_f8", int'(a_intensity), 8'hF8);

    // Full-scale negative, then silence: decay 8,7,7,6,6,5.
    repeat (4) send_a(8'h80);
    for (int w = 0; w < 6; w++) repeat (4) send_a(8'h00);
    idle_a(4);
    check("decay_level", int'(a_level), 5);
    check("decay_int", int'(a_intensity), 8'hF8);

    // Continuous valid: the sample offered during AVERAGE sets overrun.
    repeat (24) drive_a(1'b1, 1'b1, 8'($urandom), acc);
    idle_a(4);
    check("overrun_sticky", int'(a_overrun), 1);

    // Abort after 2 samples; the partial sum must not leak into the next window.
    do_reset();
    send_a(8'h7F); send_a(8'h7F);
    repeat (3) drive_a(1'b0, 1'b0, 8'h00, acc);
    check("abort_level", int'(a_level), 0);
    check("abort_int", int'(a_intensity), 0);
    idle_a(2);
    repeat (4) send_a(8'h01);
    idle_a(4);
    check("after_abort_level", int'(a_level), 1);
    check("after_abort_int", int'(a_intensity), 8'h80);

    // Randomized traffic with changing amplitude and enable drops.
    mask = 8'hFF;
    for (int i = 0; i < 1500; i++) begin
      if (i % 40 == 0) begin
        case ($urandom_range(0, 4))
          0: mask = 8'h00;
          1: mask = 8'h01;
          2: mask = 8'h07;
          3: mask = 8'h1F;
          default: mask = 8'hFF;
        endcase
      end
      d = 8'($urandom) & mask;
      if ($urandom_range(0, 15) == 0) d = 8'h80;
      drive_a($urandom_range(0, 24) != 0, $urandom_range(0, 3) != 0, d, acc);
    end
    idle_a(8);
    check("pending_windows", exp_q.size(), 0);
    @(negedge clk);
    a_enable = 1'b0; a_valid = 1'b0;

    // Default parameters: 256 samples of +127 give mean 127, level 7.
    b_enable = 1'b1; b_data = 8'h7F;
    got = 0; guard = 0;
    while (got < 256 && guard < 600) begin
      @(negedge clk);
      if (b_ready) begin
        b_valid = 1'b1;
        got++;
      end else begin
        b_valid = 1'b0;
      end
      guard++;
    end
    check("b_samples_sent", got, 256);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      b_valid = 1'b0;
      if (b_done) found = 1'b1;
    end
    check("b_window_done_seen", int'(found), 1);
    @(negedge clk);
    check("b_level7", int'(b_level), 7);
    check("b_int_fe", int'(b_intensity), 8'hFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
